alarm_clock_core: RTL

- Next-generation time-of-day clock core for the Altera board clock display.
- Counts centiseconds, seconds, minutes and hours in BCD from a parametrised clock prescaler.
- Provides button-driven setting of time and alarm, plus an alarm ringer with a programmable ring duration.
- Sits between the debounced/synchronised board buttons and the seven-segment digit drivers.

---
 rtl/alarm_clock_core_if.sv | 42 ++++
 rtl/alarm_clock_core.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/alarm_clock_core_if.sv
// Board-side bundle for alarm_clock_core: button/switch levels in, BCD digits and indicators out.
// pm_o exists only when CLOCK_12H_EN is defined.
interface alarm_clock_core_if;
  logic       set_run_switch_i, setmode_i, up_i, down_i, alarm_en_i;
  logic [3:0] centisec_o, decisec_o, sec_o, decasec_o, min_o, decamin_o, hr_o, decahr_o;
  logic [3:0] alm_min_o, alm_decamin_o, alm_hr_o, alm_decahr_o;
  logic       blink_sec_o, blink_min_o, blink_hr_o, blink_alm_min_o, blink_alm_hr_o;
  logic       ring_o;
`ifdef CLOCK_12H_EN
  logic       pm_o;

  modport master (
    output set_run_switch_i, setmode_i, up_i, down_i, alarm_en_i,
    input  centisec_o, decisec_o, sec_o, decasec_o, min_o, decamin_o, hr_o, decahr_o,
    input  alm_min_o, alm_decamin_o, alm_hr_o, alm_decahr_o,
    input  blink_sec_o, blink_min_o, blink_hr_o, blink_alm_min_o, blink_alm_hr_o,
    input  ring_o, pm_o
  );
  modport slave (
    input  set_run_switch_i, setmode_i, up_i, down_i, alarm_en_i,
    output centisec_o, decisec_o, sec_o, decasec_o, min_o, decamin_o, hr_o, decahr_o,
    output alm_min_o, alm_decamin_o, alm_hr_o, alm_decahr_o,
    output blink_sec_o, blink_min_o, blink_hr_o, blink_alm_min_o, blink_alm_hr_o,
    output ring_o, pm_o
  );
`else
  modport master (
    output set_run_switch_i, setmode_i, up_i, down_i, alarm_en_i,
    input  centisec_o, decisec_o, sec_o, decasec_o, min_o, decamin_o, hr_o, decahr_o,
    input  alm_min_o, alm_decamin_o, alm_hr_o, alm_decahr_o,
    input  blink_sec_o, blink_min_o, blink_hr_o, blink_alm_min_o, blink_alm_hr_o,
    input  ring_o
  );
  modport slave (
    input  set_run_switch_i, setmode_i, up_i, down_i, alarm_en_i,
    output centisec_o, decisec_o, sec_o, decasec_o, min_o, decamin_o, hr_o, decahr_o,
    output alm_min_o, alm_decamin_o, alm_hr_o, alm_decahr_o,
    output blink_sec_o, blink_min_o, blink_hr_o, blink_alm_min_o, blink_alm_hr_o,
    output ring_o
  );
`endif
endinterface

// File: rtl/alarm_clock_core.sv
// BCD time-of-day clock with button setting and alarm ringer.
// Define CLOCK_12H_EN for 12-hour hour display and the pm_o indicator.
module alarm_clock_core #(
  parameter int TICKS_PER_CENTI = 500000,
  parameter int PRESCALE_W      = 19,
  parameter int RING_SECS       = 30
) (
  input  logic               clk_i,
  input  logic               reset_i,
  alarm_clock_core_if.slave  bus
);

  typedef enum logic [2:0] {
    RUN, SET_SEC, SET_MIN, SET_HR, SET_ALM_MIN, SET_ALM_HR
  } state_t;

  state_t                state, state_n;
  logic [PRESCALE_W-1:0] presc;
  logic [7:0]            cs, sec, mins, hr, alm_min, alm_hr, ring_cnt;
  logic [7:0]            cs_n, sec_n, min_n, hr_n, alm_min_n, alm_hr_n;
  logic                  ring, setmode_q, up_q, down_q;
  logic                  setmode_p, up_p, down_p, inc, dec;
  logic                  tick, sec_carry, trigger, cancel;

  // Two-digit BCD fields stored as {tens, ones}; max is the field's top value.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
    if (v == max)          return 8'h00;
    if (v[3:0] == 4'd9)    return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max);
    if (v == 8'h00)        return max;
    if (v[3:0] == 4'd0)    return {v[7:4] - 4'd1, 4'd9};
    return {v[7:4], v[3:0] - 4'd1};
  endfunction

  function automatic logic [7:0] bcd_adj(input logic [7:0] v, input logic [7:0] max,
                                         input logic up, input logic dn);
    if (up) return bcd_inc(v, max);
    if (dn) return bcd_dec(v, max);
    return v;
  endfunction

  assign setmode_p = bus.setmode_i & ~setmode_q;
  assign up_p      = bus.up_i & ~up_q;
  assign down_p    = bus.down_i & ~down_q;
  assign inc       = up_p & ~down_p;
  assign dec       = down_p & ~up_p;

  always_ff @(posedge clk_i) begin
    if (reset_i) state <= RUN;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (!bus.set_run_switch_i) state_n = RUN;
    else if (setmode_p) begin
      case (state)
        RUN:         state_n = SET_SEC;
        SET_SEC:     state_n = SET_MIN;
        SET_MIN:     state_n = SET_HR;
        SET_HR:      state_n = SET_ALM_MIN;
        SET_ALM_MIN: state_n = SET_ALM_HR;
        default:     state_n = RUN;
      endcase
    end
  end

  assign tick      = (state == RUN) && (presc == PRESCALE_W'(TICKS_PER_CENTI - 1));
  assign sec_carry = tick && (cs == 8'h99);

  // Full carry chain resolves in one edge; set states touch only their own field.
  always_comb begin
    cs_n      = cs;
    sec_n     = sec;
    min_n     = mins;
    hr_n      = hr;
    alm_min_n = alm_min;
    alm_hr_n  = alm_hr;
    if (state != RUN) cs_n = 8'h00;
    case (state)
      RUN: if (tick) begin
        cs_n = bcd_inc(cs, 8'h99);
        if (cs == 8'h99) begin
          sec_n = bcd_inc(sec, 8'h59);
          if (sec == 8'h59) begin
            min_n = bcd_inc(mins, 8'h59);
            if (mins == 8'h59) hr_n = bcd_inc(hr, 8'h23);
          end
        end
      end
      SET_SEC:     sec_n     = bcd_adj(sec, 8'h59, inc, dec);
      SET_MIN:     min_n     = bcd_adj(mins, 8'h59, inc, dec);
      SET_HR:      hr_n      = bcd_adj(hr, 8'h23, inc, dec);
      SET_ALM_MIN: alm_min_n = bcd_adj(alm_min, 8'h59, inc, dec);
      SET_ALM_HR:  alm_hr_n  = bcd_adj(alm_hr, 8'h23, inc, dec);
      default: ;
    endcase
  end

  // Only a counted rollover onto hh:mm:00.00 can trigger; set-state writes never do.
  assign trigger = tick && bus.alarm_en_i && (cs_n == 8'h00) && (sec_n == 8'h00) &&
                   (min_n == alm_min) && (hr_n == alm_hr);
  assign cancel  = ((state == RUN) && (up_p || down_p)) || !bus.alarm_en_i || (state_n != RUN);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      presc     <= '0;
      cs        <= 8'h00;
      sec       <= 8'h00;
      mins      <= 8'h00;
      hr        <= 8'h00;
      alm_min   <= 8'h00;
      alm_hr    <= 8'h00;
      ring      <= 1'b0;
      ring_cnt  <= 8'd0;
      setmode_q <= 1'b0;
      up_q      <= 1'b0;
      down_q    <= 1'b0;
    end else begin
      setmode_q <= bus.setmode_i;
      up_q      <= bus.up_i;
      down_q    <= bus.down_i;
      presc     <= (tick || state != RUN) ? '0 : presc + PRESCALE_W'(1);
      cs        <= cs_n;
      sec       <= sec_n;
      mins      <= min_n;
      hr        <= hr_n;
      alm_min   <= alm_min_n;
      alm_hr    <= alm_hr_n;
      if (cancel) begin
        ring     <= 1'b0;
        ring_cnt <= 8'd0;
      end else if (trigger) begin
        ring     <= 1'b1;
        ring_cnt <= 8'(RING_SECS);
      end else if (sec_carry && ring_cnt != 8'd0) begin
        ring_cnt <= ring_cnt - 8'd1;
        if (ring_cnt == 8'd1) ring <= 1'b0;
      end
    end
  end

  assign bus.centisec_o    = cs[3:0];
  assign bus.decisec_o     = cs[7:4];
  assign bus.sec_o         = sec[3:0];
  assign bus.decasec_o     = sec[7:4];
  assign bus.min_o         = mins[3:0];
  assign bus.decamin_o     = mins[7:4];
  assign bus.alm_min_o     = alm_min[3:0];
  assign bus.alm_decamin_o = alm_min[7:4];
  assign bus.blink_sec_o     = (state == SET_SEC);
  assign bus.blink_min_o     = (state == SET_MIN);
  assign bus.blink_hr_o      = (state == SET_HR);
  assign bus.blink_alm_min_o = (state == SET_ALM_MIN);
  assign bus.blink_alm_hr_o  = (state == SET_ALM_HR);
  assign bus.ring_o          = ring;

`ifdef CLOCK_12H_EN
  // Returns {pm, display BCD}; storage stays 24-hour.
  function automatic logic [8:0] to_12h(input logic [7:0] h);
    logic [4:0] b, d;
    b = 5'(h[7:4]) * 5'd10 + 5'(h[3:0]);
    d = (b >= 5'd12) ? b - 5'd12 : b;
    if (d == 5'd0) d = 5'd12;
    return {b >= 5'd12, (d >= 5'd10) ? {4'd1, 4'(d - 5'd10)} : {4'd0, d[3:0]}};
  endfunction

  logic [8:0] hr12, alm12;
  assign hr12              = to_12h(hr);
  assign alm12             = to_12h(alm_hr);
  assign bus.hr_o          = hr12[3:0];
  assign bus.decahr_o      = hr12[7:4];
  assign bus.pm_o          = hr12[8];
  assign bus.alm_hr_o      = alm12[3:0];
  assign bus.alm_decahr_o  = alm12[7:4];
`else
  assign bus.hr_o          = hr[3:0];
  assign bus.decahr_o      = hr[7:4];
  assign bus.alm_hr_o      = alm_hr[3:0];
  assign bus.alm_decahr_o  = alm_hr[7:4];
`endif

endmodule
